barrido_display: RTL
====================

Name: barrido_display

Overview:
- Parametrised multiplexed seven-segment driver.
- Selects one of two binary counts with `sw` and converts it to BCD using a sequential double-dabble FSM.
- Latches the result tear-free and time-multiplexes N digits onto a single shared cathode bus with one-hot anodes.
- Sits between the count/control logic and the board display pins.

Parameters:
- N_DIGITOS, 4, number of digits/anodes (1..8).
- W_CUENTA, 14, width of cuenta1/cuenta2 (binary, unsigned).
- DIV_REFRESCO, 50000, clock cycles per digit slot (min 2).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- sw  in  1  1 selects cuenta1, 0 selects cuenta2.
- cuenta1  in  W_CUENTA  binary value A.
- cuenta2  in  W_CUENTA  binary value B.
- catodo  out  8  segment pattern, active-low; bit7..bit1 = a..g, bit0 = dp.
- anodo  out  N_DIGITOS  digit enable, active-low one-hot; bit0 = rightmost (units) digit.
- desborde  out  1  level; latched value exceeds 10^N_DIGITOS-1.
- conv_lista  out  1  one-cycle pulse when the display register updates.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: anodo = all ones, catodo = 8'hFF, desborde = 0, conv_lista = 0. Prescaler = 0, digit index = 0, display register = 0, FSM = CAPTURA.
- Conversion FSM, runs continuously:
  - CAPTURA: sample (sw ? cuenta1 : cuenta2) into the shift register; clear the BCD accumulator (4*N_DIGITOS bits); go to DESPLAZA.
  - DESPLAZA: exactly W_CUENTA cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, taking in the binary MSB. Then go to FIN.
  - FIN: copy the BCD into the display register. Set desborde = (captured value > 10^N_DIGITOS-1). Pulse conv_lista. Go to CAPTURA.
  - Period is W_CUENTA+2 cycles; conv_lista pulses every W_CUENTA+2 cycles.
  - A stable input is displayed no later than 2*(W_CUENTA+2) cycles after it is applied.
- Input changes (sw or either count) after CAPTURA do not affect the conversion in flight; they are taken at the next CAPTURA.
- BCD bits above the N_DIGITOS digits are discarded. Overflow is decided only by the comparison against 10^N_DIGITOS-1.
- Scan:
  - Prescaler counts 0..DIV_REFRESCO-1 and wraps.
  - On terminal count, the digit index advances: it goes 0 to 0 on the first strobe after reset, then increments modulo N_DIGITOS (N-1 wraps to 0).
  - anodo and catodo are registered and change on the same edge. anodo = ~(1<<index); catodo = pattern of the display-register digit at index.
  - Outputs stay blanked (all ones) from reset until the first terminal count, i.e. DIV_REFRESCO cycles.
- The display register may change at FIN while a digit is lit. The new value appears at the next digit strobe; the active slot is not rewritten.
- Segment patterns:
  - 0 = 00000011
  - 1 = 10011111
  - 2 = 00100101
  - 3 = 00001101
  - 4 = 10011001
  - 5 = 01001001
  - 6 = 01000001
  - 7 = 00011111
  - 8 = 00000001
  - 9 = 00001001
  - Dash = 11111101; blank = 11111111.
  - Non-BCD nibble (unreachable) maps to blank. dp is always off (bit0 = 1).
- When desborde = 1, every digit shows dash.
- Reset mid-conversion aborts the conversion. The display register clears and no conv_lista pulse is issued for the aborted conversion.
- N_DIGITOS = 1 is legal: anodo is constant 0 after the first strobe.

Optional Feature:
- Macro BLANK_CEROS_EN.
- Defined: leading-zero suppression. A digit at index k > 0 shows blank when it and all higher digits are zero. Digit 0 is always shown, so value 0 displays a single 0. Overflow dashes take precedence over blanking.
- Undefined: all digits are shown, including leading zeros.

Test Plan (N_DIGITOS=4, W_CUENTA=14, DIV_REFRESCO=4):
1. Assert reset 3 cycles, then release. Before the first strobe: anodo = 1111, catodo = FF, desborde = 0. After 4 cycles: anodo = 1110, catodo = 00000011.
2. sw=1, cuenta1=1234; wait for conv_lista. Scan shows anodo 1110 with 10011001, 1101 with 00001101, 1011 with 00100101, 0111 with 10011111, each slot lasting 4 cycles, then wraps to 1110.
3. sw=0, cuenta2=10000 -> desborde = 1 after conv_lista; all four slots show 11111101. Then set cuenta2=9999 -> desborde = 0; all slots show 00001001.
4. Toggle sw (cuenta1=5, cuenta2=8) two cycles after CAPTURA -> the next conv_lista shows 0005. The following conversion shows the newly selected value 0008.
5. Assert reset during DESPLAZA with value 4321 -> no conv_lista pulse; outputs FF/1111; the first conversion after release displays the current input.
6. With BLANK_CEROS_EN, value 7 -> digits 3..1 show 11111111, digit 0 shows 00011111. Value 0 -> digit 0 shows 00000011, others blank. Value 10000 -> all dashes.

Source files
------------

// File: rtl/barrido_display_if.sv
// Count inputs and display-pin outputs of barrido_display grouped as one bus.
// master drives the counts and select, slave (the display driver) drives the pins.
interface barrido_display_if #(
    parameter int N_DIGITOS = 4,
    parameter int W_CUENTA  = 14
);
    logic                 sw;
    logic [W_CUENTA-1:0]  cuenta1;
    logic [W_CUENTA-1:0]  cuenta2;
    logic [7:0]           catodo;
    logic [N_DIGITOS-1:0] anodo;
    logic                 desborde;
    logic                 conv_lista;

    modport master (
        output sw, cuenta1, cuenta2,
        input  catodo, anodo, desborde, conv_lista
    );

    modport slave (
        input  sw, cuenta1, cuenta2,
        output catodo, anodo, desborde, conv_lista
    );
endinterface

// File: rtl/barrido_display.sv
// Multiplexed seven-segment driver: sequential double-dabble BCD conversion plus digit scan.
// Define BLANK_CEROS_EN to suppress leading zeros on the upper digits.
module barrido_display #(
    parameter int N_DIGITOS    = 4,
    parameter int W_CUENTA     = 14,
    parameter int DIV_REFRESCO = 50000
) (
    input  logic             clk,
    input  logic             reset,
    barrido_display_if.slave bus
);
    localparam int W_BCD = 4 * N_DIGITOS;
    localparam int W_IDX = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int W_PRE = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam int W_CNT = (W_CUENTA > 1) ? $clog2(W_CUENTA) : 1;

    function automatic logic [63:0] limiteMax(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] LIMITE = limiteMax(N_DIGITOS);

    function automatic logic [7:0] patron(input logic [3:0] d);
        case (d)
            4'd0:    patron = 8'b0000_0011;
            4'd1:    patron = 8'b1001_1111;
            4'd2:    patron = 8'b0010_0101;
            4'd3:    patron = 8'b0000_1101;
            4'd4:    patron = 8'b1001_1001;
            4'd5:    patron = 8'b0100_1001;
            4'd6:    patron = 8'b0100_0001;
            4'd7:    patron = 8'b0001_1111;
            4'd8:    patron = 8'b0000_0001;
            4'd9:    patron = 8'b0000_1001;
            default: patron = 8'b1111_1111;
        endcase
    endfunction

    typedef enum logic [1:0] {CAPTURA, DESPLAZA, FIN} estado_t;

    estado_t             r_estado;
    estado_t             w_siguiente;
    logic [W_CUENTA-1:0] w_entrada;
    logic [W_CUENTA-1:0] r_shift;
    logic [W_BCD-1:0]    r_bcd;
    logic [W_BCD-1:0]    w_bcdSig;
    logic [W_BCD-1:0]    r_disp;
    logic [W_CNT-1:0]    r_cnt;
    logic [3:0]          w_nib;
    logic                w_acarreo;
    logic                r_excede;
    logic                r_desborde;
    logic                r_convLista;

    logic [W_PRE-1:0]     r_presc;
    logic [W_IDX-1:0]     r_idx;
    logic [W_IDX-1:0]     w_idxSig;
    logic                 r_activo;
    logic                 w_strobe;
    logic [3:0]           w_digito;
    logic [7:0]           w_catodoSig;
    logic [7:0]           r_catodo;
    logic [N_DIGITOS-1:0] r_anodo;
`ifdef BLANK_CEROS_EN
    logic                 w_apagar;
`endif

    assign w_entrada = bus.sw ? bus.cuenta1 : bus.cuenta2;

    always_ff @(posedge clk) begin
        if (reset) r_estado <= CAPTURA;
        else       r_estado <= w_siguiente;
    end

    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            CAPTURA:  w_siguiente = DESPLAZA;
            DESPLAZA: if (r_cnt == W_CNT'(W_CUENTA - 1)) w_siguiente = FIN;
            FIN:      w_siguiente = CAPTURA;
            default:  w_siguiente = CAPTURA;
        endcase
    end

    // One double-dabble step; each adjusted nibble's MSB carries into the next nibble.
    always_comb begin
        w_bcdSig  = '0;
        w_nib     = 4'd0;
        w_acarreo = r_shift[W_CUENTA-1];
        for (int k = 0; k < N_DIGITOS; k++) begin
            w_nib = r_bcd[4*k +: 4];
            if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
            w_bcdSig[4*k +: 4] = {w_nib[2:0], w_acarreo};
            w_acarreo = w_nib[3];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_excede    <= 1'b0;
            r_disp      <= '0;
            r_desborde  <= 1'b0;
            r_convLista <= 1'b0;
        end else begin
            r_convLista <= 1'b0;
            case (r_estado)
                CAPTURA: begin
                    r_shift  <= w_entrada;
                    r_bcd    <= '0;
                    r_cnt    <= '0;
                    r_excede <= (64'(w_entrada) > LIMITE);
                end
                DESPLAZA: begin
                    r_bcd   <= w_bcdSig;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + W_CNT'(1);
                end
                FIN: begin
                    r_disp      <= r_bcd;
                    r_desborde  <= r_excede;
                    r_convLista <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_strobe = (r_presc == W_PRE'(DIV_REFRESCO - 1));

    // The first strobe after reset only un-blanks digit 0; later strobes advance the index.
    always_comb begin
        w_idxSig = r_idx;
        if (r_activo) begin
            if (r_idx == W_IDX'(N_DIGITOS - 1)) w_idxSig = '0;
            else                                w_idxSig = r_idx + W_IDX'(1);
        end
    end

    always_comb begin
        w_digito = 4'd0;
`ifdef BLANK_CEROS_EN
        w_apagar = 1'b0;
`endif
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (w_idxSig == W_IDX'(k)) begin
                w_digito = r_disp[4*k +: 4];
`ifdef BLANK_CEROS_EN
                w_apagar = (k > 0) && ((r_disp >> (4*k)) == '0);
`endif
            end
        end
    end

    always_comb begin
        w_catodoSig = patron(w_digito);
`ifdef BLANK_CEROS_EN
        if (w_apagar) w_catodoSig = 8'b1111_1111;
`endif
        if (r_desborde) w_catodoSig = 8'b1111_1101;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_activo <= 1'b0;
            r_anodo  <= '1;
            r_catodo <= 8'hFF;
        end else begin
            if (w_strobe) begin
                r_presc  <= '0;
                r_idx    <= w_idxSig;
                r_activo <= 1'b1;
                r_anodo  <= ~(N_DIGITOS'(1) << w_idxSig);
                r_catodo <= w_catodoSig;
            end else begin
                r_presc <= r_presc + W_PRE'(1);
            end
        end
    end

    assign bus.catodo     = r_catodo;
    assign bus.anodo      = r_anodo;
    assign bus.desborde   = r_desborde;
    assign bus.conv_lista = r_convLista;
endmodule
